// File: rtl/reg_rename_file_if.sv
// Operand-read, ROB-query, rename and commit signals of the register rename file.
// master = decode/issue/ROB side, slave = the register file.
interface reg_rename_file_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NRP   = 2
);
  localparam int unsigned RW = $clog2(NREG);

  logic [NRP*RW-1:0]    rd_reg;
  logic [NRP*XLEN-1:0]  rd_val;
  logic [NRP-1:0]       rd_dep;
  logic [NRP*ROB_W-1:0] rd_tag;
  logic [NRP*ROB_W-1:0] rob_qtag;
  logic [NRP-1:0]       rob_qrdy;
  logic [NRP*XLEN-1:0]  rob_qval;
  logic                 ren_en;
  logic [RW-1:0]        ren_reg;
  logic [ROB_W-1:0]     ren_tag;
  logic                 cmt_en;
  logic [RW-1:0]        cmt_reg;
  logic [ROB_W-1:0]     cmt_tag;
  logic [XLEN-1:0]      cmt_val;

  modport master (
    output rd_reg, rob_qrdy, rob_qval, ren_en, ren_reg, ren_tag,
    output cmt_en, cmt_reg, cmt_tag, cmt_val,
    input  rd_val, rd_dep, rd_tag, rob_qtag
  );

  modport slave (
    input  rd_reg, rob_qrdy, rob_qval, ren_en, ren_reg, ren_tag,
    input  cmt_en, cmt_reg, cmt_tag, cmt_val,
    output rd_val, rd_dep, rd_tag, rob_qtag
  );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with busy/tag rename table; operand reads forward
// same-cycle renames, same-cycle commits and ready ROB results.
module reg_rename_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NRP   = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear_flag,
  output logic [$clog2(NREG+1)-1:0]  busy_cnt,
  reg_rename_file_if.slave           bus
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NREG+1);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [ROB_W-1:0] tag_q  [NREG];
  logic [ROB_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
  logic [RW-1:0]    rd_idx [NRP];

  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    // Commit writes the value even under flush; busy is only released when the
    // committing tag is still the latest producer and no new rename claims the reg.
    if (bus.cmt_en && bus.cmt_reg != '0) begin
      regs_d[bus.cmt_reg] = bus.cmt_val;
      if (busy_q[bus.cmt_reg] && tag_q[bus.cmt_reg] == bus.cmt_tag &&
          !(bus.ren_en && bus.ren_reg == bus.cmt_reg) && !clear_flag) begin
        busy_d[bus.cmt_reg] = 1'b0;
      end
    end
    if (clear_flag) begin
      busy_d = '0;
      for (int i = 0; i < NREG; i++) tag_d[i] = '0;
    end else if (bus.ren_en && bus.ren_reg != '0) begin
      busy_d[bus.ren_reg] = 1'b1;
      tag_d[bus.ren_reg]  = bus.ren_tag;
    end
    busy_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + {{(CW-1){1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      regs_q     <= '{default: '0};
      tag_q      <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else if (rdy_in) begin
      regs_q     <= regs_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  always_comb begin
    for (int p = 0; p < NRP; p++) rd_idx[p] = bus.rd_reg[p*RW +: RW];
  end

  always_comb begin
    bus.rd_val   = '0;
    bus.rd_dep   = '0;
    bus.rd_tag   = '0;
    bus.rob_qtag = '0;
    for (int p = 0; p < NRP; p++) begin
      bus.rob_qtag[p*ROB_W +: ROB_W] = tag_q[rd_idx[p]];
      if (rd_idx[p] == '0) begin
        // x0 reads as a ready zero
      end else if (bus.ren_en && bus.ren_reg == rd_idx[p]) begin
        bus.rd_dep[p]              = 1'b1;
        bus.rd_tag[p*ROB_W +: ROB_W] = bus.ren_tag;
      end else if (busy_q[rd_idx[p]] && bus.cmt_en && bus.cmt_reg == rd_idx[p] &&
                   bus.cmt_tag == tag_q[rd_idx[p]]) begin
        bus.rd_val[p*XLEN +: XLEN]   = bus.cmt_val;
        bus.rd_tag[p*ROB_W +: ROB_W] = tag_q[rd_idx[p]];
      end else if (busy_q[rd_idx[p]]) begin
        bus.rd_tag[p*ROB_W +: ROB_W] = tag_q[rd_idx[p]];
        if (bus.rob_qrdy[p]) bus.rd_val[p*XLEN +: XLEN] = bus.rob_qval[p*XLEN +: XLEN];
        else                 bus.rd_dep[p] = 1'b1;
      end else begin
        bus.rd_val[p*XLEN +: XLEN] = regs_q[rd_idx[p]];
      end
    end
  end
endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: stimulus queues expected responses, a
// negedge monitor pops them and compares against the live DUT outputs.
module tb_reg_rename_file;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int ROB_W = 4;
  localparam int NRP = 2;
  localparam int RW = 5;

  typedef struct {
    string       name;
    int          kind;  // 0 read port, 1 busy_cnt, 2 rob_qtag
    int          port;
    logic [31:0] val;
    logic        dep;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rdy, clear;
  logic [5:0] busy_cnt;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;

  reg_rename_file_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP)) bus ();

  reg_rename_file #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rdy_in    (rdy),
    .clear_flag(clear),
    .busy_cnt  (busy_cnt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    bus.rd_reg = '0; bus.rob_qrdy = '0; bus.rob_qval = '0;
    bus.ren_en = 1'b0; bus.ren_reg = '0; bus.ren_tag = '0;
    bus.cmt_en = 1'b0; bus.cmt_reg = '0; bus.cmt_tag = '0; bus.cmt_val = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input logic [4:0] r);
    bus.rd_reg[p*RW +: RW] = r;
  endtask

  task automatic ren(input logic [4:0] r, input logic [3:0] t);
    bus.ren_en = 1'b1; bus.ren_reg = r; bus.ren_tag = t;
  endtask

  task automatic cmt(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    bus.cmt_en = 1'b1; bus.cmt_reg = r; bus.cmt_tag = t; bus.cmt_val = v;
  endtask

  task automatic qrdy(input int p, input logic [31:0] v);
    bus.rob_qrdy[p] = 1'b1; bus.rob_qval[p*XLEN +: XLEN] = v;
  endtask

  task automatic exp_rd(input string n, input int p, input logic [31:0] v, input logic d,
                        input logic [3:0] t);
    exp_t e;
    e.name = n; e.kind = 0; e.port = p; e.val = v; e.dep = d; e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic exp_cnt(input string n, input int c);
    exp_t e;
    e.name = n; e.kind = 1; e.port = 0; e.val = c; e.dep = 1'b0; e.tag = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_qt(input string n, input int p, input logic [3:0] t);
    exp_t e;
    e.name = n; e.kind = 2; e.port = p; e.val = '0; e.dep = 1'b0; e.tag = t;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] av;
      logic        ad;
      logic [3:0]  at;
      e = exp_q.pop_front();
      n_chk++;
      if (e.kind == 0) begin
        av = bus.rd_val[e.port*XLEN +: XLEN];
        ad = bus.rd_dep[e.port];
        at = bus.rd_tag[e.port*ROB_W +: ROB_W];
        if (av === e.val && ad === e.dep && at === e.tag) n_pass++;
        else $display("FAIL %s: got val=%h dep=%b tag=%0d, want val=%h dep=%b tag=%0d",
                      e.name, av, ad, at, e.val, e.dep, e.tag);
      end else if (e.kind == 1) begin
        if ({26'd0, busy_cnt} === e.val) n_pass++;
        else $display("FAIL %s: got busy_cnt=%0d, want %0d", e.name, busy_cnt, e.val);
      end else begin
        at = bus.rob_qtag[e.port*ROB_W +: ROB_W];
        if (at === e.tag) n_pass++;
        else $display("FAIL %s: got rob_qtag=%0d, want %0d", e.name, at, e.tag);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    cyc(); rst = 1'b1;
    cyc();
    // T1: reset state, rename of x0 is dropped
    rd(0, 5); ren(0, 3); rd(1, 0);
    exp_rd("t1_x5", 0, 0, 0, 0); exp_rd("t1_x0_ren", 1, 0, 0, 0); exp_cnt("t1_cnt", 0);
    cyc(); rd(0, 0);
    exp_rd("t1_x0", 0, 0, 0, 0); exp_cnt("t1_cnt_x0", 0);
    // T2: rename forwarding and ROB result forwarding
    cyc(); ren(5, 2); rd(0, 5);
    exp_rd("t2_same", 0, 0, 1, 2);
    cyc(); rd(0, 5);
    exp_rd("t2_pend", 0, 0, 1, 2); exp_qt("t2_qtag", 0, 2); exp_cnt("t2_cnt", 1);
    cyc(); rd(0, 5); rd(1, 5); qrdy(0, 32'hAB);
    exp_rd("t2_fwd", 0, 32'hAB, 0, 2); exp_rd("t2_p1_pend", 1, 0, 1, 2);
    // T3: commit forwarding then busy release
    cyc(); cmt(5, 2, 32'h11); rd(0, 5);
    exp_rd("t3_same", 0, 32'h11, 0, 2); exp_cnt("t3_cnt_pre", 1);
    cyc(); rd(0, 5);
    exp_rd("t3_after", 0, 32'h11, 0, 0); exp_cnt("t3_cnt", 0);
    // T4: rename beats same-cycle commit
    cyc(); ren(5, 2);
    cyc(); cmt(5, 2, 32'h22); ren(5, 7); rd(0, 5);
    exp_rd("t4_same", 0, 0, 1, 7);
    cyc(); rd(0, 5);
    exp_rd("t4_busy", 0, 0, 1, 7); exp_cnt("t4_cnt", 1);
    cyc(); clear = 1'b1;
    cyc(); rd(0, 5);
    exp_rd("t4_val", 0, 32'h22, 0, 0); exp_cnt("t4_clr_cnt", 0);
    // T5: stale-tag commit writes value but keeps busy
    cyc(); ren(5, 4);
    cyc(); ren(5, 6);
    cyc(); cmt(5, 4, 32'd9); rd(0, 5);
    exp_rd("t5_same", 0, 0, 1, 6);
    cyc(); rd(0, 5);
    exp_rd("t5_busy", 0, 0, 1, 6); exp_cnt("t5_cnt", 1);
    cyc(); clear = 1'b1;
    cyc(); rd(0, 5);
    exp_rd("t5_val", 0, 32'd9, 0, 0);
    // T6: flush with concurrent commit and rename
    cyc(); ren(3, 1);
    cyc(); ren(4, 2);
    cyc(); ren(6, 3);
    cyc(); clear = 1'b1; cmt(3, 1, 32'h55); ren(8, 5); rd(0, 8);
    exp_cnt("t6_cnt3", 3); exp_rd("t6_same_ren", 0, 0, 1, 5);
    cyc(); rd(0, 3); rd(1, 8);
    exp_cnt("t6_cnt0", 0); exp_rd("t6_x3", 0, 32'h55, 0, 0); exp_rd("t6_x8", 1, 0, 0, 0);
    // rdy_in low holds every update, including flush
    cyc(); ren(9, 9);
    cyc(); rdy = 1'b0; ren(10, 1); cmt(9, 9, 32'h77); clear = 1'b1;
    exp_cnt("hold_cnt_in", 1);
    cyc(); rdy = 1'b0; cmt(9, 9, 32'h77);
    cyc(); rd(0, 9); rd(1, 10);
    exp_rd("hold_x9", 0, 0, 1, 9); exp_rd("hold_x10", 1, 0, 0, 0); exp_cnt("hold_cnt", 1);
    // reset wins over rdy_in low
    cyc(); rst = 1'b1; rdy = 1'b0;
    cyc(); rd(0, 9);
    exp_rd("rst_x9", 0, 0, 0, 0); exp_cnt("rst_cnt", 0);
    cyc();
    cyc();
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
